// File: rtl/up_sample_2x_pkg.sv
// Shared definitions for the pyramid pixel pipeline: default image geometry,
// pixel width and the upsampler's row-copy state encoding.
package up_sample_2x_pkg;

  // Downsampled image geometry, shared with the down-sampler and Gaussian wrapper.
  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int PIX_DW = 8;

  // LIVE builds the first copy of a row from the FIFO; REPLAY rebuilds it from the line buffer.
  typedef enum logic {
    LIVE   = 1'b0,
    REPLAY = 1'b1
  } us_state_e;

endpackage

// File: rtl/up_sample_2x_line_buf_ram.sv
// Simple dual-port line buffer holding one input row: synchronous write,
// synchronous read with one cycle of latency, written to map onto block RAM.
module line_buf_ram #(
  parameter int DEPTH = 320,
  parameter int AW    = 9,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: no reset on the array or its read register; a reset would stop block-RAM inference,
  // and every entry is written in LIVE before REPLAY ever reads it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/up_sample_2x.sv
// 2x pixel upsampler: each popped pixel is emitted twice per row, and each row is
// emitted twice, the second copy replayed from an internal line buffer.
module up_sample_2x
  import up_sample_2x_pkg::*;
#(
  parameter int IN_W = IMG_W,
  parameter int IN_H = IMG_H,
  parameter int DW   = PIX_DW,
  parameter int CW   = $clog2(IN_W),
  parameter int RW   = $clog2(IN_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic          fifo_valid,
  input  logic [DW-1:0] fifo_dout,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_eol,
  output logic          dout_eof,
  output logic          err_ovf
);

  localparam logic [CW:0]   LAST_COL = (CW+1)'(2*IN_W - 1);
  localparam logic [CW:0]   PRE_LAST = (CW+1)'(2*IN_W - 2);
  localparam logic [CW:0]   ROW_PIX  = (CW+1)'(IN_W);
  localparam logic [RW-1:0] LAST_ROW = RW'(IN_H - 1);

  us_state_e     state;
  logic [CW:0]   col;      // output beat index within the current row
  logic [CW:0]   rd_cnt;   // FIFO reads issued in the current LIVE row
  logic [CW:0]   rep_cnt;  // line-buffer entries loaded in the current REPLAY row
  logic [RW-1:0] row;
  logic          pending;
  logic          phase;    // 0: first copy of the held pixel, 1: second copy
  logic [DW-1:0] ram_q;

  logic accept;
  logic hold_free;
  logic row_done;
  logic live_load;
  logic rep_load;
  logic rd_ok;

  assign accept    = dout_valid && dout_ready;
  // The hold register is free when empty or when its second copy leaves this cycle.
  assign hold_free = !dout_valid || (accept && phase);
  assign row_done  = accept && phase && (col == LAST_COL);
  assign live_load = fifo_valid && pending;
  assign rep_load  = (state == REPLAY) && hold_free && (rep_cnt < ROW_PIX);
  assign rd_ok     = (state == LIVE) && !fifo_empty && !pending && hold_free
                     && (rd_cnt < ROW_PIX);
  // NOTE: rd_en is decoded from live flops and inputs, so it is masked while rst is held
  // to keep every output at 0 during reset.
  assign fifo_rd_en = rd_ok && !rst;

  // At a FIFO capture the hold register is empty, so col is exactly twice the pixel column.
  line_buf_ram #(
    .DEPTH (IN_W),
    .AW    (CW),
    .DW    (DW)
  ) u_line_buf (
    .clk   (clk),
    .we    (live_load),
    .waddr (col[CW:1]),
    .wdata (fifo_dout),
    .raddr (rep_cnt[CW-1:0]),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LIVE;
      col        <= '0;
      row        <= '0;
      rd_cnt     <= '0;
      rep_cnt    <= '0;
      pending    <= 1'b0;
      phase      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_eol   <= 1'b0;
      dout_eof   <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      if (fifo_rd_en) pending <= 1'b1;
      else if (fifo_valid) pending <= 1'b0;

      if (fifo_valid && !pending) err_ovf <= 1'b1;
      if (fifo_rd_en) rd_cnt <= rd_cnt + 1'b1;

      if (live_load) begin
        dout       <= fifo_dout;
        dout_valid <= 1'b1;
        phase      <= 1'b0;
        dout_eol   <= 1'b0;
        dout_eof   <= 1'b0;
      end else if (rep_load) begin
        // rep_cnt is held for at least one cycle before each load, so ram_q matches it.
        dout       <= ram_q;
        dout_valid <= 1'b1;
        phase      <= 1'b0;
        dout_eol   <= 1'b0;
        dout_eof   <= 1'b0;
        rep_cnt    <= rep_cnt + 1'b1;
      end else if (accept) begin
        if (!phase) begin
          phase    <= 1'b1;
          dout_eol <= (col == PRE_LAST);
          dout_eof <= (state == REPLAY) && (col == PRE_LAST) && (row == LAST_ROW);
        end else begin
          dout_valid <= 1'b0;
          dout_eol   <= 1'b0;
          dout_eof   <= 1'b0;
        end
      end

      if (accept) col <= (col == LAST_COL) ? '0 : col + 1'b1;

      if (row_done) begin
        unique case (state)
          LIVE: begin
            state  <= REPLAY;
            rd_cnt <= '0;
          end
          REPLAY: begin
            state   <= LIVE;
            rep_cnt <= '0;
            row     <= (row == LAST_ROW) ? '0 : row + 1'b1;
          end
          default: state <= LIVE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_up_sample_2x.sv
// Self-checking bench for up_sample_2x: a small FIFO model feeds pixels and every
// accepted beat is compared against a frame-level expectation built from the pixel list.
module tb_up_sample_2x;

  localparam int IN_W      = 4;
  localparam int IN_H      = 2;
  localparam int DW        = 8;
  localparam int CW        = 2;
  localparam int RW        = 1;
  localparam int ROW_BEATS = 2 * IN_W;
  localparam int FRAME_PIX = IN_W * IN_H;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          fifo_valid;
  logic [DW-1:0] fifo_dout;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_eol;
  logic          dout_eof;
  logic          err_ovf;

  up_sample_2x #(
    .IN_W (IN_W),
    .IN_H (IN_H),
    .DW   (DW),
    .CW   (CW),
    .RW   (RW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_valid (fifo_valid),
    .fifo_dout  (fifo_dout),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_eol   (dout_eol),
    .dout_eof   (dout_eof),
    .err_ovf    (err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          eol;
    logic          eof;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] frame_buf [FRAME_PIX];

  int n_tests = 0;
  int n_fail  = 0;
  int beats, rd_pulses, cyc, last_beat_cyc, eof_cyc, t;
  bit rand_mode;
  bit stalled;
  logic [DW+1:0] stall_snap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected output of one frame: rows in order, each row twice, each pixel twice.
  task automatic expect_frame();
    beat_t e;
    for (int r = 0; r < IN_H; r++)
      for (int copy = 0; copy < 2; copy++)
        for (int b = 0; b < ROW_BEATS; b++) begin
          e.data = frame_buf[r*IN_W + b/2];
          e.eol  = (b == ROW_BEATS-1);
          e.eof  = (r == IN_H-1) && (copy == 1) && (b == ROW_BEATS-1);
          exp_q.push_back(e);
        end
  endtask

  task automatic seq_frame(input int first, input bit to_fifo);
    for (int i = 0; i < FRAME_PIX; i++) begin
      frame_buf[i] = DW'(first + i);
      if (to_fifo) fifo_q.push_back(frame_buf[i]);
    end
    expect_frame();
  endtask

  // One clock: observe at the falling edge, then drive FIFO/ready 1 time unit after the rise.
  task automatic cycle();
    beat_t e;
    bit    pop;
    @(negedge clk);
    cyc++;
    if (stalled) begin
      check("stall_valid", dout_valid, 1);
      check("stall_hold", {dout, dout_eol, dout_eof}, stall_snap);
    end
    stalled    = dout_valid && !dout_ready;
    stall_snap = {dout, dout_eol, dout_eof};
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) check("extra_beat", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("dout", dout, e.data);
        check("eol", dout_eol, e.eol);
        check("eof", dout_eof, e.eof);
      end
      beats++;
      last_beat_cyc = cyc;
    end
    check("rd_en_while_empty", fifo_rd_en && fifo_empty, 0);
    if (fifo_rd_en) rd_pulses++;
    pop = fifo_rd_en && (fifo_q.size() != 0);
    @(posedge clk);
    #1;
    if (pop) begin
      fifo_dout  = fifo_q.pop_front();
      fifo_valid = 1'b1;
    end else fifo_valid = 1'b0;
    fifo_empty = (fifo_q.size() == 0) || (rand_mode && $urandom_range(0, 3) == 0);
    if (rand_mode) dout_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (beats < n && k < budget) begin
      cycle();
      k++;
    end
    check("beats_reached", beats >= n, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fifo_empty = 1'b1; fifo_valid = 1'b0; fifo_dout = '0;
    dout_ready = 1'b0; rand_mode = 1'b0; stalled = 1'b0; cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {fifo_rd_en, dout_valid, dout, dout_eol, dout_eof, err_ovf}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic frame 1..8 with downstream always ready.
    beats = 0; rd_pulses = 0;
    seq_frame(1, 1);
    fifo_empty = 1'b0; dout_ready = 1'b1;
    run_until(32, 200);
    check("basic_rd_pulses", rd_pulses, 8);
    check("basic_left", exp_q.size(), 0);

    // Backpressure on beat 5 (pixel 3, first copy) for three cycles.
    beats = 0; rd_pulses = 0;
    seq_frame(1, 1);
    fifo_empty = 1'b0;
    run_until(4, 100);
    dout_ready = 1'b0;
    t = 0;
    while (!dout_valid && t < 10) begin cycle(); t++; end
    check("bp_first_dout", dout, 3);
    check("bp_first_valid", dout_valid, 1);
    repeat (3) cycle();
    check("bp_held_dout", dout, 3);
    dout_ready = 1'b1;
    run_until(32, 200);
    check("bp_rd_pulses", rd_pulses, 8);
    check("bp_left", exp_q.size(), 0);

    // Starvation: only pixels 1,2 available, the rest arrive after 10 idle cycles.
    beats = 0; rd_pulses = 0;
    seq_frame(1, 0);
    fifo_q.push_back(8'd1); fifo_q.push_back(8'd2);
    fifo_empty = 1'b0;
    run_until(4, 100);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("starve_valid", dout_valid, 0);
      check("starve_rd_en", fifo_rd_en, 0);
    end
    for (int i = 3; i <= 8; i++) fifo_q.push_back(DW'(i));
    fifo_empty = 1'b0;
    run_until(32, 200);
    check("starve_rd_pulses", rd_pulses, 8);
    check("starve_left", exp_q.size(), 0);

    // Spurious fifo_valid while replaying row 0.
    beats = 0; rd_pulses = 0;
    seq_frame(1, 1);
    fifo_empty = 1'b0;
    run_until(10, 100);
    check("ovf_before", err_ovf, 0);
    fifo_dout = 8'hEE; fifo_valid = 1'b1;
    cycle();
    check("ovf_set", err_ovf, 1);
    run_until(32, 200);
    check("ovf_sticky", err_ovf, 1);
    check("ovf_rd_pulses", rd_pulses, 8);
    check("ovf_left", exp_q.size(), 0);

    // Reset in the middle of row 0, then a fresh frame 9..16.
    beats = 0;
    seq_frame(1, 1);
    fifo_empty = 1'b0;
    run_until(3, 100);
    #2 rst = 1'b1;
    #1;
    check("midrst_outputs", {fifo_rd_en, dout_valid, dout, dout_eol, dout_eof, err_ovf}, 0);
    fifo_q.delete(); exp_q.delete();
    fifo_valid = 1'b0; stalled = 1'b0;
    seq_frame(9, 1);
    fifo_empty = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_hold", {fifo_rd_en, dout_valid, dout, dout_eol, dout_eof, err_ovf}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    beats = 0; rd_pulses = 0;
    run_until(32, 200);
    check("midrst_rd_pulses", rd_pulses, 8);
    check("midrst_left", exp_q.size(), 0);

    // Two back-to-back frames, 1..8 then 9..16.
    beats = 0; rd_pulses = 0;
    seq_frame(1, 1);
    seq_frame(9, 1);
    fifo_empty = 1'b0;
    run_until(32, 200);
    eof_cyc = last_beat_cyc;
    run_until(33, 20);
    check("wrap_gap_ok", (last_beat_cyc - eof_cyc) <= 3, 1);
    run_until(64, 300);
    check("wrap_rd_pulses", rd_pulses, 16);
    check("wrap_left", exp_q.size(), 0);

    // Random pixels with random backpressure and random FIFO starvation.
    beats = 0;
    for (int i = 0; i < FRAME_PIX; i++) begin
      frame_buf[i] = DW'($urandom_range(0, 255));
      fifo_q.push_back(frame_buf[i]);
    end
    expect_frame();
    fifo_empty = 1'b0;
    rand_mode = 1'b1;
    run_until(32, 800);
    rand_mode = 1'b0; dout_ready = 1'b1;
    check("rand_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
